// File: rtl/tdm_mux8_pkg.sv
// tdm_mux8_pkg: shared constants and the lane-select type used by the
// 8-lane TDM mux and its matching demux.
//   N_LANES    : number of multiplexed lanes (8)
//   SEL_W      : width of a lane index (3)
//   lane_sel_t : lane index type carried alongside each word
package tdm_mux8_pkg;
    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // True for the highest-numbered lane; marks the end of a full rotation.
    function automatic logic is_last_lane(lane_sel_t sel);
        return sel == lane_sel_t'(N_LANES - 1);
    endfunction
endpackage

// File: rtl/tdm_mux8_rr_pick8.sv
// rr_pick8: combinational rotate-priority picker.
//   vld[7:0] : per-lane request
//   ptr[2:0] : lane with highest priority this cycle
//   g[2:0]   : first requesting lane in order ptr, ptr+1, ... (mod 8)
//   any      : at least one lane is requesting (g is meaningless otherwise)
module rr_pick8
    import tdm_mux8_pkg::*;
(
    input  logic [N_LANES-1:0] vld,
    input  lane_sel_t          ptr,
    output lane_sel_t          g,
    output logic               any
);
    lane_sel_t idx;
    logic      found;

    always_comb begin
        g     = '0;
        idx   = '0;
        found = 1'b0;
        // Walk lanes starting at ptr; 3-bit add wraps naturally.
        for (int j = 0; j < N_LANES; j++) begin
            idx = ptr + lane_sel_t'(j);
            if (!found && vld[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |vld;
endmodule

// File: rtl/tdm_mux8.sv
// tdm_mux8: 8-to-1 time-division multiplexer with round-robin arbitration
// and a single registered output stage (valid/ready).
//   clk, rst : clock, async active-high reset
//   i        : lane data, lane k at i[k*WIDTH +: WIDTH]
//   vld/rdy  : per-lane handshake; rdy is one-hot or zero, combinational
//   y, s     : registered output word and its lane index
//   y_vld    : registered output valid; y_rdy downstream ready
//   y_last   : registered, set when y came from lane 7
module tdm_mux8
    import tdm_mux8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_LANES*WIDTH-1:0] i,
    input  logic [N_LANES-1:0]       vld,
    output logic [N_LANES-1:0]       rdy,
    output logic [WIDTH-1:0]         y,
    output logic [SEL_W-1:0]         s,
    output logic                     y_vld,
    input  logic                     y_rdy,
    output logic                     y_last
);
    lane_sel_t        ptr;
    lane_sel_t        g;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] lane_data;

    rr_pick8 u_pick (
        .vld (vld),
        .ptr (ptr),
        .g   (g),
        .any (any)
    );

    // Stage accepts when empty or draining this edge, so it can refill
    // back-to-back at one word per cycle.
    assign load = (~y_vld | y_rdy) & any & ~rst;
    assign rdy  = load ? (N_LANES'(1) << g) : '0;

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (g == lane_sel_t'(k)) lane_data = i[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y      <= '0;
            s      <= '0;
            y_vld  <= 1'b0;
            y_last <= 1'b0;
            ptr    <= '0;
        end else if (load) begin
            y      <= lane_data;
            s      <= g;
            y_last <= is_last_lane(g);
            y_vld  <= 1'b1;
            ptr    <= g + lane_sel_t'(1);
        end else if (y_vld && y_rdy) begin
            // Drained with nothing to refill: word fields and ptr hold.
            y_vld  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tdm_mux8.sv
module tb_tdm_mux8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*WIDTH-1:0] i;
    logic [7:0]       vld;
    logic [7:0]       rdy;
    logic [WIDTH-1:0] y;
    logic [2:0]       s;
    logic             y_vld;
    logic             y_rdy;
    logic             y_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_mux8 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .i      (i),
        .vld    (vld),
        .rdy    (rdy),
        .y      (y),
        .s      (s),
        .y_vld  (y_vld),
        .y_rdy  (y_rdy),
        .y_last (y_last)
    );

    typedef struct {
        logic [7:0] vld;
        logic       y_rdy;
        logic [7:0] e_rdy;
        logic [7:0] e_y;
        logic [2:0] e_s;
        logic       e_vld;
        logic       e_last;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [7:0] v, input logic r, input logic [7:0] er,
                       input logic [7:0] ey, input logic [2:0] es, input logic ev,
                       input logic el, input string tag);
        vec_t t;
        t.vld = v; t.y_rdy = r; t.e_rdy = er; t.e_y = ey; t.e_s = es;
        t.e_vld = ev; t.e_last = el; t.tag = tag;
        vecs.push_back(t);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic [2:0] es,
                           input logic ev, input logic el);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".s"}, 32'(s), 32'(es));
        chk({tag, ".y_vld"}, 32'(y_vld), 32'(ev));
        chk({tag, ".y_last"}, 32'(y_last), 32'(el));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) i[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
        rst = 1'b1; vld = 8'hFF; y_rdy = 1'b1;

        // All lanes valid, y_rdy=1: s 0..7 then 0; y_last only with 17.
        for (int k = 0; k < 8; k++)
            add(8'hFF, 1'b1, 8'(1 << k), 8'(8'h10 + k), 3'(k), 1'b1, k == 7, "rr");
        add(8'hFF, 1'b1, 8'h01, 8'h10, 3'd0, 1'b1, 1'b0, "rr_wrap");
        // Backpressure: word 10/s0 held, rdy=0; then next is 11/s1.
        for (int k = 0; k < 4; k++)
            add(8'hFF, 1'b0, 8'h00, 8'h10, 3'd0, 1'b1, 1'b0, "bp_hold");
        add(8'hFF, 1'b1, 8'h02, 8'h11, 3'd1, 1'b1, 1'b0, "bp_release");
        // Drain with no requests: y_vld drops, fields hold.
        add(8'h00, 1'b1, 8'h00, 8'h11, 3'd1, 1'b0, 1'b0, "drain");
        // Sparse lanes 2,5,7 (ptr=2), each dropping vld after acceptance.
        add(8'hA4, 1'b1, 8'h04, 8'h12, 3'd2, 1'b1, 1'b0, "sparse2");
        add(8'hA0, 1'b1, 8'h20, 8'h15, 3'd5, 1'b1, 1'b0, "sparse5");
        add(8'h80, 1'b1, 8'h80, 8'h17, 3'd7, 1'b1, 1'b1, "sparse7");
        add(8'h00, 1'b1, 8'h00, 8'h17, 3'd7, 1'b0, 1'b1, "sparse_end");
        // Lanes 0 and 7 only (ptr=0): alternate 0,7,0,7.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) add(8'h81, 1'b1, 8'h01, 8'h10, 3'd0, 1'b1, 1'b0, "wrap0");
            else            add(8'h81, 1'b1, 8'h80, 8'h17, 3'd7, 1'b1, 1'b1, "wrap7");
        end
        // Single valid lane granted every cycle regardless of ptr.
        for (int k = 0; k < 3; k++)
            add(8'h08, 1'b1, 8'h08, 8'h13, 3'd3, 1'b1, 1'b0, "single");

        // Reset state, rdy held low even with requests pending.
        #2;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset.rdy", 32'(rdy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            vld = vecs[n].vld;
            y_rdy = vecs[n].y_rdy;
            #1;
            chk({vecs[n].tag, ".rdy"}, 32'(rdy), 32'(vecs[n].e_rdy));
            @(posedge clk);
            #1;
            chk_out(vecs[n].tag, vecs[n].e_y, vecs[n].e_s, vecs[n].e_vld, vecs[n].e_last);
        end

        // Async reset between edges while holding y=13, s=3.
        vld = 8'hFF; y_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("arst.rdy", 32'(rdy), 32'h0);
        @(posedge clk);
        #1;
        chk_out("arst_edge", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; y_rdy = 1'b1;
        #1;
        chk("post_rst.rdy", 32'(rdy), 32'h01);
        @(posedge clk);
        #1;
        chk_out("post_rst", 8'h10, 3'd0, 1'b1, 1'b0);
        #1;
        chk("post_rst.rdy2", 32'(rdy), 32'h02);
        @(posedge clk);
        #1;
        chk_out("post_rst2", 8'h11, 3'd1, 1'b1, 1'b0);

        // Loopback through a 1-to-8 demux: lane bit at y[0] must land on
        // the demux output selected by s, matching the source lane's bit.
        for (int k = 0; k < 8; k++) i[k*WIDTH +: WIDTH] = 8'(k % 2 == 0 ? 1 : 0);
        for (int n = 0; n < 8; n++) begin
            logic [7:0] demux_y;
            int         lane;
            lane = (n + 2) % 8;
            @(posedge clk);
            #1;
            demux_y = 8'(y[0]) << s;
            chk("loop.s", 32'(s), 32'(lane));
            chk("loop.bit", 32'(demux_y[lane]), 32'(lane % 2 == 0 ? 1 : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
